mem_hs_ctrl: RTL and testbench

- Clocked memory-interface controller between the processor datapath and the 256-byte asynchronous big-endian RAM.
- Accepts one-cycle-registered load/store requests of byte, halfword, word or doubleword size.
- Drives the RAM's Enable/ReadWrite/Address/DataIn/DataSize lines and waits on the MFC handshake with no timing assumption.
- Splits a doubleword into two word accesses and returns size-masked read data with a single completion pulse.

---
 rtl/mem_hs_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_mem_hs_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_hs_ctrl.sv
// Load/store controller for a 256-byte asynchronous big-endian RAM with an MFC handshake.
// Define MEM_TIMEOUT_EN to abort an access that sees no MFC within TIMEOUT_CYC ACCESS cycles.
module mem_hs_ctrl #(
    parameter int ADDR_W      = 8,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Req,
    input  logic              Write,
    input  logic [1:0]        Size,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [63:0]       WData,
    output logic [63:0]       RData,
    output logic              Done,
    output logic              Err,
    output logic              Busy,
    output logic              MemEnable,
    output logic              MemReadWrite,
    output logic [ADDR_W-1:0] MemAddress,
    output logic [31:0]       MemDataIn,
    output logic [1:0]        MemDataSize,
    input  logic [31:0]       MemDataOut,
    input  logic              MFC
);
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ACCESS, S_RECOVER, S_FAULT} state_t;

    state_t            state_q, state_d;
    logic              write_q, write_d;
    logic [1:0]        size_q, size_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [63:0]       wdata_q, wdata_d;
    logic [63:0]       rdata_q, rdata_d;
    logic              second_q, second_d;
    logic [1:0]        sync_q;
    logic              mfc_s;
    logic              misaligned;
    logic              last_access;
    logic              aborted;
    logic [63:0]       rd_capture;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             abort_q, abort_d;
    assign aborted = abort_q;
`else
    assign aborted = 1'b0;
`endif

    assign mfc_s       = sync_q[1];
    assign Busy        = (state_q != S_IDLE);
    assign MemEnable   = (state_q == S_ACCESS);
    assign RData       = rdata_q;
    assign last_access = (size_q != 2'b11) || second_q;

    always_comb begin
        misaligned = 1'b0;
        case (Size)
            2'b01:   misaligned = Addr[0];
            2'b10:   misaligned = |Addr[1:0];
            2'b11:   misaligned = |Addr[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    // Big-endian RAM returns narrow data right-justified; stale upper bits are discarded here.
    always_comb begin
        rd_capture = 64'd0;
        case (size_q)
            2'b00:   rd_capture = {56'd0, MemDataOut[7:0]};
            2'b01:   rd_capture = {48'd0, MemDataOut[15:0]};
            2'b10:   rd_capture = {32'd0, MemDataOut};
            default: rd_capture = second_q ? {rdata_q[63:32], MemDataOut} : {MemDataOut, 32'd0};
        endcase
    end

    always_comb begin
        MemReadWrite = 1'b0;
        MemAddress   = '0;
        MemDataIn    = 32'd0;
        MemDataSize  = 2'b00;
        if (state_q == S_SETUP || state_q == S_ACCESS || state_q == S_RECOVER) begin
            MemReadWrite = ~write_q;
            MemAddress   = addr_q;
            MemDataSize  = (size_q == 2'b11) ? 2'b10 : size_q;
            case (size_q)
                2'b00:   MemDataIn = {24'd0, wdata_q[7:0]};
                2'b01:   MemDataIn = {16'd0, wdata_q[15:0]};
                2'b10:   MemDataIn = wdata_q[31:0];
                default: MemDataIn = second_q ? wdata_q[31:0] : wdata_q[63:32];
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        size_d   = size_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        second_d = second_q;
`ifdef MEM_TIMEOUT_EN
        cnt_d    = cnt_q;
        abort_d  = abort_q;
`endif
        Done     = 1'b0;
        Err      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Req) begin
                    write_d  = Write;
                    size_d   = Size;
                    addr_d   = Addr;
                    wdata_d  = WData;
                    rdata_d  = 64'd0;
                    second_d = 1'b0;
`ifdef MEM_TIMEOUT_EN
                    abort_d  = 1'b0;
`endif
                    state_d  = misaligned ? S_FAULT : S_SETUP;
                end
            end
            S_FAULT: begin
                Done    = 1'b1;
                Err     = 1'b1;
                state_d = S_IDLE;
            end
            S_SETUP: begin
`ifdef MEM_TIMEOUT_EN
                cnt_d   = '0;
`endif
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                if (mfc_s) begin
                    if (!write_q)
                        rdata_d = rd_capture;
                    state_d = S_RECOVER;
                end
`ifdef MEM_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    abort_d = 1'b1;
                    rdata_d = 64'd0;
                    state_d = S_RECOVER;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            S_RECOVER: begin
                if (last_access || aborted) begin
                    Done    = 1'b1;
                    Err     = aborted;
                    state_d = S_IDLE;
                end else begin
                    addr_d   = addr_q + ADDR_W'(4);
                    second_d = 1'b1;
                    state_d  = S_SETUP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= S_IDLE;
            write_q  <= 1'b0;
            size_q   <= 2'b00;
            addr_q   <= '0;
            wdata_q  <= 64'd0;
            rdata_q  <= 64'd0;
            second_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt_q    <= '0;
            abort_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            size_q   <= size_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            second_q <= second_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q    <= cnt_d;
            abort_q  <= abort_d;
`endif
        end
    end

    // Held clear while the RAM is disabled so a lingering MFC from the last access is never seen.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            sync_q <= 2'b00;
        else if (!MemEnable)
            sync_q <= 2'b00;
        else
            sync_q <= {sync_q[0], MFC};
    end
endmodule

// File: tb/tb_mem_hs_ctrl.sv
// Directed bench for mem_hs_ctrl with a behavioural big-endian RAM and an expected-result queue.
module tb_mem_hs_ctrl;
    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Req = 1'b0;
    logic        Write = 1'b0;
    logic [1:0]  Size = 2'b00;
    logic [7:0]  Addr = 8'd0;
    logic [63:0] WData = 64'd0;
    logic [63:0] RData;
    logic        Done, Err, Busy;
    logic        MemEnable, MemReadWrite;
    logic [7:0]  MemAddress;
    logic [31:0] MemDataIn;
    logic [1:0]  MemDataSize;
    logic [31:0] MemDataOut;
    logic        MFC;

    mem_hs_ctrl #(.ADDR_W(8), .TIMEOUT_CYC(8)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Req(Req), .Write(Write), .Size(Size),
        .Addr(Addr), .WData(WData), .RData(RData), .Done(Done), .Err(Err), .Busy(Busy),
        .MemEnable(MemEnable), .MemReadWrite(MemReadWrite), .MemAddress(MemAddress),
        .MemDataIn(MemDataIn), .MemDataSize(MemDataSize), .MemDataOut(MemDataOut), .MFC(MFC)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    // RAM model: MFC rises after mfc_delay enabled cycles; narrow reads leave stale upper bits.
    logic [7:0]  mem [256];
    int          mfc_delay = 0;
    int          en_cnt = 0;
    logic        wr_done = 1'b0;
    logic [31:0] last_dout = 32'd0;
    logic [31:0] dout;
    logic [7:0]  a1, a2, a3;

    assign a1 = MemAddress + 8'd1;
    assign a2 = MemAddress + 8'd2;
    assign a3 = MemAddress + 8'd3;
    assign MFC = MemEnable && (en_cnt >= mfc_delay);
    assign MemDataOut = dout;

    always_comb begin
        dout = last_dout;
        if (MemEnable && MemReadWrite && MFC) begin
            case (MemDataSize)
                2'b00:   dout[7:0]  = mem[MemAddress];
                2'b01:   dout[15:0] = {mem[MemAddress], mem[a1]};
                default: dout       = {mem[MemAddress], mem[a1], mem[a2], mem[a3]};
            endcase
        end
    end

    always @(posedge Clk) begin
        if (!MemEnable) begin
            en_cnt  <= 0;
            wr_done <= 1'b0;
        end else begin
            if (en_cnt < 100000) en_cnt <= en_cnt + 1;
            if (MFC && !MemReadWrite && !wr_done) begin
                wr_done <= 1'b1;
                case (MemDataSize)
                    2'b00: mem[MemAddress] <= MemDataIn[7:0];
                    2'b01: begin
                        mem[MemAddress] <= MemDataIn[15:8];
                        mem[a1]         <= MemDataIn[7:0];
                    end
                    default: begin
                        mem[MemAddress] <= MemDataIn[31:24];
                        mem[a1]         <= MemDataIn[23:16];
                        mem[a2]         <= MemDataIn[15:8];
                        mem[a3]         <= MemDataIn[7:0];
                    end
                endcase
            end
            if (MemReadWrite && MFC) last_dout <= dout;
        end
    end

    int         en_pulses = 0;
    int         addr_moves = 0;
    int         err_wo_done = 0;
    logic       en_prev = 1'b0;
    logic [7:0] addr_prev = 8'd0;
    always @(posedge Clk) begin
        en_prev   <= MemEnable;
        addr_prev <= MemAddress;
        if (MemEnable && !en_prev) en_pulses <= en_pulses + 1;
        if (MemEnable && en_prev && MemAddress != addr_prev) addr_moves <= addr_moves + 1;
        if (Err && !Done) err_wo_done <= err_wo_done + 1;
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [63:0] rd;
        logic        chk_rd;
        logic        err;
        int          lat;
    } exp_t;
    exp_t sb[$];

    task automatic op(input string tag, input logic wr, input logic [1:0] sz, input logic [7:0] a,
                      input logic [63:0] wd, input logic [63:0] exp_rd, input logic chk_rd,
                      input logic exp_err, input int exp_lat, input int exp_pulses);
        exp_t e;
        int   t0, p0, m0;
        logic got, busy_drop;
        e.rd = exp_rd; e.chk_rd = chk_rd; e.err = exp_err; e.lat = exp_lat;
        sb.push_back(e);
        p0 = en_pulses;
        m0 = addr_moves;
        @(posedge Clk); #1;
        Req = 1'b1; Write = wr; Size = sz; Addr = a; WData = wd;
        t0 = cyc;
        @(posedge Clk); #1;
        Req = 1'b0;
        got = 1'b0;
        busy_drop = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge Clk);
            if (Done) begin
                got = 1'b1;
                break;
            end
            if (!Busy) busy_drop = 1'b1;
        end
        chk({tag, "_done_seen"}, 64'(got), 64'd1);
        if (got) begin
            e = sb.pop_front();
            $display("op %s: lat=%0d err=%0b rdata=%h", tag, cyc - t0, Err, RData);
            chk({tag, "_latency"}, 64'(cyc - t0), 64'(e.lat));
            chk({tag, "_err"}, 64'(Err), 64'(e.err));
            chk({tag, "_busy_at_done"}, 64'(Busy), 64'd1);
            chk({tag, "_busy_held"}, 64'(busy_drop), 64'd0);
            if (e.chk_rd) chk({tag, "_rdata"}, RData, e.rd);
        end
        @(negedge Clk);
        chk({tag, "_done_single"}, 64'(Done), 64'd0);
        chk({tag, "_busy_after"}, 64'(Busy), 64'd0);
        chk({tag, "_enable_pulses"}, 64'(en_pulses - p0), 64'(exp_pulses));
        chk({tag, "_addr_stable"}, 64'(addr_moves - m0), 64'd0);
    endtask

    initial begin
        #3;
        chk("reset_outputs", {RData[31:0], 5'd0, Done, Err, Busy, MemEnable, MemReadWrite, MemDataSize, MemAddress, MemDataIn[15:0]}, 64'd0);
        chk("reset_rdata", RData, 64'd0);
        @(negedge Clk);
        Reset_n = 1'b1;

        op("st_word", 1'b1, 2'b10, 8'h10, 64'h00000000DEADBEEF, 64'd0, 1'b0, 1'b0, 5, 1);
        chk("mem_word", 64'({mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]}), 64'hDEADBEEF);
        op("ld_word", 1'b0, 2'b10, 8'h10, 64'd0, 64'h00000000DEADBEEF, 1'b1, 1'b0, 5, 1);
        op("ld_byte", 1'b0, 2'b00, 8'h11, 64'd0, 64'h00000000000000AD, 1'b1, 1'b0, 5, 1);
        op("ld_half", 1'b0, 2'b01, 8'h12, 64'd0, 64'h000000000000BEEF, 1'b1, 1'b0, 5, 1);
        op("st_half", 1'b1, 2'b01, 8'h40, 64'hFFFFFFFFFFFF1234, 64'd0, 1'b0, 1'b0, 5, 1);
        chk("mem_half", 64'({mem[8'h40], mem[8'h41]}), 64'h1234);
        op("st_byte", 1'b1, 2'b00, 8'h43, 64'h00000000000000A5, 64'd0, 1'b0, 1'b0, 5, 1);
        chk("mem_byte", 64'(mem[8'h43]), 64'hA5);

        op("st_dword", 1'b1, 2'b11, 8'hF8, 64'h0123456789ABCDEF, 64'd0, 1'b0, 1'b0, 10, 2);
        chk("mem_dword", {mem[8'hF8], mem[8'hF9], mem[8'hFA], mem[8'hFB],
                          mem[8'hFC], mem[8'hFD], mem[8'hFE], mem[8'hFF]}, 64'h0123456789ABCDEF);
        op("ld_dword", 1'b0, 2'b11, 8'hF8, 64'd0, 64'h0123456789ABCDEF, 1'b1, 1'b0, 10, 2);

        op("mis_half", 1'b0, 2'b01, 8'h21, 64'd0, 64'd0, 1'b1, 1'b1, 1, 0);
        op("mis_word", 1'b1, 2'b10, 8'h13, 64'h1111111111111111, 64'd0, 1'b1, 1'b1, 1, 0);
        op("mis_dword", 1'b0, 2'b11, 8'h0C, 64'd0, 64'd0, 1'b1, 1'b1, 1, 0);
        chk("mem_untouched", 64'({mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]}), 64'hDEADBEEF);

        mfc_delay = 20;
        op("ld_slow", 1'b0, 2'b10, 8'h10, 64'd0, 64'h00000000DEADBEEF, 1'b1, 1'b0, 25, 1);
        mfc_delay = 0;

`ifdef MEM_TIMEOUT_EN
        mfc_delay = 100000;
        op("ld_timeout", 1'b0, 2'b10, 8'h10, 64'd0, 64'd0, 1'b1, 1'b1, 10, 1);
        mfc_delay = 0;
`endif

        mfc_delay = 50;
        @(posedge Clk); #1;
        Req = 1'b1; Write = 1'b0; Size = 2'b10; Addr = 8'h10;
        @(posedge Clk); #1;
        Req = 1'b0;
        repeat (4) @(negedge Clk);
        chk("rst_mid_enable_before", 64'(MemEnable), 64'd1);
        #2 Reset_n = 1'b0;
        #1;
        $display("reset mid-access: en=%0b busy=%0b done=%0b", MemEnable, Busy, Done);
        chk("rst_mid_outputs", {61'd0, MemEnable, Busy, Done}, 64'd0);
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        mfc_delay = 0;
        op("ld_after_rst", 1'b0, 2'b10, 8'h10, 64'd0, 64'h00000000DEADBEEF, 1'b1, 1'b0, 5, 1);

        chk("err_without_done", 64'(err_wo_done), 64'd0);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
